// File: rtl/shift_sequencer.sv
// Multi-cycle LC-3b SHF shifter (LSHF/RSHFL/RSHFA) shared by two requesters
// with round-robin arbitration and a tagged valid/ready response channel.
module shift_sequencer #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [1:0]         req0_op,
  input  logic [WIDTH-1:0]   req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [1:0]         req1_op,
  input  logic [WIDTH-1:0]   req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_id,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_RESP} state_t;
  typedef enum logic [1:0] {
    OP_LSHF  = 2'b00,
    OP_RSHFL = 2'b01,
    OP_RSV   = 2'b10,
    OP_RSHFA = 2'b11
  } op_t;

  localparam int unsigned   RW     = SHAMT_W + 4;
  localparam int unsigned   STEP_U = STEP;
  localparam logic [RW-1:0] STEP_R = RW'(STEP);

  state_t             state;
  op_t                op_r;
  logic [WIDTH-1:0]   work_r;
  logic [SHAMT_W-1:0] rem_r;
  logic               last_r;

  logic               grant0;
  logic               grant1;
  logic [1:0]         acc_op;
  logic [WIDTH-1:0]   acc_data;
  logic [SHAMT_W-1:0] acc_shamt;
  logic [WIDTH-1:0]   work_nxt;
  logic [SHAMT_W-1:0] rem_nxt;

  // last_r names the requester granted most recently; the other one wins a tie.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_r);
    grant1     = req1_valid & (~req0_valid | ~last_r);
    req0_ready = (state == S_IDLE) & grant0;
    req1_ready = (state == S_IDLE) & grant1;
    acc_op     = grant1 ? req1_op    : req0_op;
    acc_data   = grant1 ? req1_data  : req0_data;
    acc_shamt  = grant1 ? req1_shamt : req0_shamt;
  end

  // Up to STEP single-bit shifts per cycle, stopping once the remaining count is used up.
  always_comb begin
    work_nxt = work_r;
    for (int unsigned i = 0; i < STEP_U; i++) begin
      if (RW'(i) < RW'(rem_r)) begin
        case (op_r)
          OP_LSHF:  work_nxt = {work_nxt[WIDTH-2:0], 1'b0};
          OP_RSHFL: work_nxt = {1'b0, work_nxt[WIDTH-1:1]};
          OP_RSHFA: work_nxt = {work_nxt[WIDTH-1], work_nxt[WIDTH-1:1]};
          default:  work_nxt = work_nxt;
        endcase
      end
    end
    if (RW'(rem_r) > STEP_R) rem_nxt = rem_r - SHAMT_W'(STEP);
    else                     rem_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_r      <= OP_LSHF;
      work_r    <= '0;
      rem_r     <= '0;
      last_r    <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant0 | grant1) begin
            op_r   <= op_t'(acc_op);
            work_r <= acc_data;
            rem_r  <= acc_shamt;
            rsp_id <= grant1;
            last_r <= grant1;
            busy   <= 1'b1;
            if (acc_shamt == '0 || acc_op == OP_RSV) state <= S_DONE;
            else                                     state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          work_r <= work_nxt;
          rem_r  <= rem_nxt;
          if (rem_nxt == '0) state <= S_DONE;
        end
        // Registering the result here gives the one-cycle response stage after the last shift.
        S_DONE: begin
          rsp_valid <= 1'b1;
          rsp_data  <= work_r;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: STEP=1 instance with both requesters,
// plus a STEP=4 instance for the latency scaling case.
module tb_shift_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // STEP=1 instance
  logic        r0v = 1'b0, r1v = 1'b0, r0r, r1r;
  logic [1:0]  r0op = '0, r1op = '0;
  logic [15:0] r0d = '0, r1d = '0;
  logic [3:0]  r0s = '0, r1s = '0;
  logic        rv, rr = 1'b1, rid, busy;
  logic [15:0] rd;

  shift_sequencer #(.WIDTH(16), .SHAMT_W(4), .STEP(1)) u1 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(r0v), .req0_ready(r0r), .req0_op(r0op), .req0_data(r0d), .req0_shamt(r0s),
    .req1_valid(r1v), .req1_ready(r1r), .req1_op(r1op), .req1_data(r1d), .req1_shamt(r1s),
    .rsp_valid(rv), .rsp_ready(rr), .rsp_data(rd), .rsp_id(rid), .busy(busy)
  );

  // STEP=4 instance, requester 1 unused
  logic        a_v = 1'b0, a_r, b_v = 1'b0, b_r;
  logic [1:0]  a_op = '0, b_op = '0;
  logic [15:0] a_d = '0, b_d = '0;
  logic [3:0]  a_s = '0, b_s = '0;
  logic        a_rv, a_rr = 1'b1, a_rid, a_busy;
  logic [15:0] a_rd;

  shift_sequencer #(.WIDTH(16), .SHAMT_W(4), .STEP(4)) u4 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(a_v), .req0_ready(a_r), .req0_op(a_op), .req0_data(a_d), .req0_shamt(a_s),
    .req1_valid(b_v), .req1_ready(b_r), .req1_op(b_op), .req1_data(b_d), .req1_shamt(b_s),
    .rsp_valid(a_rv), .rsp_ready(a_rr), .rsp_data(a_rd), .rsp_id(a_rid), .busy(a_busy)
  );

  typedef struct {
    logic [15:0] data;
    logic        id;
    int unsigned t;
    int unsigned lat;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int   grants[$];
  bit   seen1 = 1'b0;
  bit   seen4 = 1'b0;
  int unsigned last_hs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int unsigned lat_of(input logic [1:0] op, input logic [3:0] s, input int unsigned step);
    if (op == 2'b10) return 1;
    return 1 + (int'(s) + step - 1) / step;
  endfunction

  task automatic issue(input int port, input logic [1:0] op, input logic [15:0] data,
                       input logic [3:0] shamt, input logic [15:0] expd, output int unsigned t_acc);
    exp_t e;
    bit   ok = 1'b0;
    t_acc = 0;
    @(negedge clk);
    if (port == 0) begin r0v = 1'b1; r0op = op; r0d = data; r0s = shamt; end
    else           begin r1v = 1'b1; r1op = op; r1d = data; r1s = shamt; end
    for (int n = 0; n < 300; n++) begin
      #1;
      if ((port == 0) ? r0r : r1r) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout port=%0d actual=no_ready required=ready", port);
    end else begin
      t_acc  = cyc + 1;
      e.data = expd; e.id = port[0]; e.t = t_acc; e.lat = lat_of(op, shamt, 1);
      q1.push_back(e);
      grants.push_back(port);
      @(posedge clk);
    end
    #1;
    if (port == 0) r0v = 1'b0; else r1v = 1'b0;
  endtask

  task automatic issue4(input logic [1:0] op, input logic [15:0] data,
                        input logic [3:0] shamt, input logic [15:0] expd);
    exp_t e;
    bit   ok = 1'b0;
    @(negedge clk);
    a_v = 1'b1; a_op = op; a_d = data; a_s = shamt;
    for (int n = 0; n < 300; n++) begin
      #1;
      if (a_r) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout_s4 actual=no_ready required=ready");
    end else begin
      e.data = expd; e.id = 1'b0; e.t = cyc + 1; e.lat = lat_of(op, shamt, 4);
      q4.push_back(e);
      @(posedge clk);
    end
    #1;
    a_v = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (q1.size() == 0 && q4.size() == 0 && !busy && !a_busy) return;
    end
    checks++; failures++;
    $display("FAIL drain_timeout actual=pending=%0d/%0d required=0", q1.size(), q4.size());
  endtask

  // STEP=1 monitor: latency on first sight, payload and ready-gating every cycle in RESP.
  always @(negedge clk) begin
    if (reset_n && rv) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rsp actual=valid data=%0h required=no_valid", rd);
      end else begin
        if (!seen1) begin
          seen1 = 1'b1;
          check("latency", cyc - q1[0].t, q1[0].lat);
        end
        check("rsp_data", rd, q1[0].data);
        check("rsp_id", rid, q1[0].id);
        check("req_ready_in_resp", {r0r, r1r}, 2'b00);
        if (rr) begin
          last_hs = cyc + 1;
          void'(q1.pop_front());
          seen1 = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && a_rv) begin
      if (q4.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rsp_s4 actual=valid data=%0h required=no_valid", a_rd);
      end else begin
        if (!seen4) begin
          seen4 = 1'b1;
          check("latency_s4", cyc - q4[0].t, q4[0].lat);
        end
        check("rsp_data_s4", a_rd, q4[0].data);
        check("rsp_id_s4", a_rid, q4[0].id);
        if (a_rr) begin
          void'(q4.pop_front());
          seen4 = 1'b0;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t, t2;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_rsp_valid", rv, 1'b0);
    check("reset_rsp_data", rd, 16'h0000);
    check("reset_rsp_id", rid, 1'b0);
    reset_n = 1'b1;

    // RSHFA 8001 by 4 on both STEP variants
    fork
      issue(0, 2'b11, 16'h8001, 4'd4, 16'hF800, t);
      issue4(2'b11, 16'h8001, 4'd4, 16'hF800);
    join
    wait_idle();

    // Maximum shift amounts
    issue(1, 2'b01, 16'h8001, 4'd15, 16'h0001, t);
    issue(1, 2'b00, 16'h0001, 4'd15, 16'h8000, t);
    issue(1, 2'b11, 16'h8000, 4'd15, 16'hFFFF, t);
    issue(0, 2'b11, 16'h7FFF, 4'd15, 16'h0000, t);
    issue(0, 2'b00, 16'hFFFF, 4'd1,  16'hFFFE, t);
    wait_idle();
    issue4(2'b00, 16'h0001, 4'd15, 16'h8000);
    issue4(2'b01, 16'hF000, 4'd5,  16'h0780);
    wait_idle();

    // Zero shift and reserved op pass the operand through
    issue(0, 2'b00, 16'h1234, 4'd0, 16'h1234, t);
    issue(1, 2'b10, 16'h1234, 4'd9, 16'h1234, t);
    wait_idle();

    // Consumer stalls 10 cycles in RESP while another request waits
    @(posedge clk); #2 rr = 1'b0;
    issue(0, 2'b01, 16'hF0F0, 4'd3, 16'h1E1E, t);
    for (int n = 0; n < 100 && !rv; n++) @(negedge clk);
    fork
      issue(1, 2'b00, 16'h00FF, 4'd4, 16'h0FF0, t2);
      begin repeat (10) @(posedge clk); #2 rr = 1'b1; end
    join
    check("accept_after_handshake", t2, last_hs + 1);
    wait_idle();

    // Reset during SHIFT abandons the operation
    issue(1, 2'b00, 16'h0003, 4'd12, 16'h3000, t);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_busy", busy, 1'b0);
    check("midreset_rsp_valid", rv, 1'b0);
    check("midreset_rsp_data", rd, 16'h0000);
    check("midreset_rsp_id", rid, 1'b0);
    q1.delete();
    seen1 = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("postreset_idle", busy, 1'b0);

    // Both requesters continuously valid: grants alternate starting with 0
    grants.delete();
    fork
      for (int i = 0; i < 4; i++) begin
        int unsigned ta;
        logic [15:0] e0;
        e0 = 16'h0001 << (i + 1);
        issue(0, 2'b00, 16'h0001, 4'(i + 1), e0, ta);
      end
      for (int j = 0; j < 4; j++) begin
        int unsigned tb;
        logic [15:0] e1;
        e1 = 16'h8000 >> (j + 1);
        issue(1, 2'b01, 16'h8000, 4'(j + 1), e1, tb);
      end
    join
    wait_idle();
    check("grant_count", grants.size(), 8);
    for (int i = 0; i < 8 && i < grants.size(); i++)
      check($sformatf("grant_order_%0d", i), grants[i], i % 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
